axis_out_packer: RTL and testbench

AXIS_OUT_PACKER -- requirements
Module: axis_out_packer

---
 rtl/axis_out_packer_pkg.sv | 38 +++
 rtl/axis_out_packer.sv | 121 ++++++++++++
 tb/tb_axis_out_packer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_out_packer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : axis_out_packer_pkg                                       |
// | Brief   : Shared defaults, state type and derived-constant helpers  |
// |           for the AXI-Stream wide-to-narrow packer.                 |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package axis_out_packer_pkg;

  // Default geometry; every instance may override these through its parameters.
  localparam int unsigned C_S_WORDS     = 32;
  localparam int unsigned C_M_WORDS     = 8;
  localparam int unsigned C_WORD_WIDTH  = 32;
  localparam int unsigned C_USER_WIDTH  = 8;
  localparam int unsigned C_I_IS_CONFIG = 0;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  // Number of output slices per input beat.
  function automatic int unsigned calc_ns(input int unsigned s_words, input int unsigned m_words);
    return (s_words + m_words - 1) / m_words;
  endfunction

  // Words carried by the final slice (a full slice when the split is exact).
  function automatic int unsigned calc_tail_words(input int unsigned s_words, input int unsigned m_words);
    return ((s_words % m_words) == 0) ? m_words : (s_words % m_words);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : axis_out_packer                                           |
// | Brief   : Holds one wide AXI-Stream beat and replays it as          |
// |           ceil(S_WORDS/M_WORDS) narrow beats, LSB word first.       |
// |           Config-marked beats are accepted and dropped.             |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module axis_out_packer
  import axis_out_packer_pkg::*;
#(
  parameter int unsigned S_WORDS     = C_S_WORDS,
  parameter int unsigned M_WORDS     = C_M_WORDS,
  parameter int unsigned WORD_WIDTH  = C_WORD_WIDTH,
  parameter int unsigned USER_WIDTH  = C_USER_WIDTH,
  parameter int unsigned I_IS_CONFIG = C_I_IS_CONFIG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_data,
  input  logic [USER_WIDTH-1:0]         s_user,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_data,
  output logic [M_WORDS-1:0]            m_keep,
  output logic                          m_last
);

  localparam int unsigned C_NS         = calc_ns(S_WORDS, M_WORDS);
  localparam int unsigned C_TAIL_WORDS = calc_tail_words(S_WORDS, M_WORDS);
  localparam int unsigned C_CNT_W      = calc_idx_w(C_NS);
  localparam int unsigned C_IN_W       = S_WORDS * WORD_WIDTH;
  localparam int unsigned C_SLICE_W    = M_WORDS * WORD_WIDTH;
  localparam int unsigned C_HOLD_W     = C_NS * C_SLICE_W;
  localparam int unsigned C_IDX_W      = calc_idx_w(C_HOLD_W);

  localparam logic [M_WORDS-1:0] C_FULL_KEEP = {M_WORDS{1'b1}};
  localparam logic [M_WORDS-1:0] C_TAIL_KEEP = {M_WORDS{1'b1}} >> (M_WORDS - C_TAIL_WORDS);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT  = C_CNT_W'(C_NS - 1);

  state_t                 r_state;
  logic [C_CNT_W-1:0]     r_cnt;
  logic [C_HOLD_W-1:0]    r_data;
  logic                   r_last;

  logic [C_HOLD_W-1:0]    w_s_padded;
  logic [C_IDX_W-1:0]     w_base;
  logic                   w_last_slice;
  logic                   w_s_fire;
  logic                   w_load;
  logic                   w_m_fire;
  logic                   w_unused_user;

  // The held copy is padded to a whole number of slices; the pad stays zero
  // so the unkept words of the final slice read as zero.
  generate
    if (C_HOLD_W > C_IN_W) begin : g_pad
      assign w_s_padded = {{(C_HOLD_W - C_IN_W){1'b0}}, s_data};
    end else begin : g_nopad
      assign w_s_padded = s_data;
    end
  endgenerate

  // Only the config bit of s_user steers behaviour.
  assign w_unused_user = ^s_user;

  assign w_last_slice = (r_cnt == C_LAST_CNT);
  assign m_valid      = (r_state == ST_SEND);
  // Ready never looks at s_valid: free when empty, or when the final slice leaves now.
  assign s_ready      = (r_state == ST_EMPTY) || (w_last_slice && m_ready);
  assign w_s_fire     = s_valid && s_ready;
  assign w_load       = w_s_fire && !s_user[I_IS_CONFIG];
  assign w_m_fire     = m_valid && m_ready;

  assign w_base = C_IDX_W'(r_cnt * C_SLICE_W);
  assign m_data = r_data[w_base +: C_SLICE_W];
  assign m_keep = m_valid ? (w_last_slice ? C_TAIL_KEEP : C_FULL_KEEP) : '0;
  assign m_last = m_valid && r_last && w_last_slice;

  // Hold/replay state machine: load a beat, step the slice counter per transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_state <= ST_SEND;
            r_cnt   <= '0;
            r_data  <= w_s_padded;
            r_last  <= s_last;
          end
        end
        ST_SEND: begin
          if (w_m_fire) begin
            if (w_last_slice) begin
              r_cnt <= '0;
              if (w_load) begin
                r_data <= w_s_padded;
                r_last <= s_last;
              end else begin
                r_state <= ST_EMPTY;
              end
            end else begin
              r_cnt <= r_cnt + C_CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_out_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_axis_out_packer                                        |
// | Brief   : Self-checking bench: a 10->3 word instance against a      |
// |           slice-queue reference model, and an exact 8->4 instance   |
// |           with a directed back-to-back stream.                      |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_axis_out_packer;

  localparam int unsigned AS = 10, AM = 3, AW = 8, AU = 4, ACFG = 2, ANS = 4;
  localparam int unsigned BS = 8, BM = 4, BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
  logic [AS*AW-1:0]    a_s_data;
  logic [AU-1:0]       a_s_user;
  logic [AM*AW-1:0]    a_m_data;
  logic [AM-1:0]       a_m_keep;

  logic                b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic [BS*BW-1:0]    b_s_data;
  logic [7:0]          b_s_user;
  logic [BM*BW-1:0]    b_m_data;
  logic [BM-1:0]       b_m_keep;

  int n_checks = 0;
  int n_errs   = 0;

  axis_out_packer #(
    .S_WORDS(AS), .M_WORDS(AM), .WORD_WIDTH(AW), .USER_WIDTH(AU), .I_IS_CONFIG(ACFG)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_user(a_s_user), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_keep(a_m_keep), .m_last(a_m_last)
  );

  axis_out_packer #(
    .S_WORDS(BS), .M_WORDS(BM), .WORD_WIDTH(BW), .USER_WIDTH(8), .I_IS_CONFIG(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_user(b_s_user), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_keep(b_m_keep), .m_last(b_m_last)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  typedef struct {
    logic [AM*AW-1:0] d;
    logic [AM-1:0]    k;
    logic             l;
  } slice_t;

  slice_t q[$];
  logic   post_rst = 1'b0;

  // Queue holds the slices still owed for the held beat; outputs and ready follow from it.
  always @(negedge clk) begin : a_model
    logic   exp_sr;
    slice_t e;
    if (rst) begin
      q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_m_valid", a_m_valid, 1'b0);
        chk("rst_m_keep",  a_m_keep,  '0);
        chk("rst_m_last",  a_m_last,  1'b0);
        chk("rst_m_data",  a_m_data,  '0);
        post_rst = 1'b0;
      end
      exp_sr = (q.size() == 0) || (q.size() == 1 && a_m_ready);
      chk("s_ready", a_s_ready, exp_sr);
      chk("m_valid", a_m_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_data", a_m_data, q[0].d);
        chk("m_keep", a_m_keep, q[0].k);
        chk("m_last", a_m_last, q[0].l);
        if (a_m_ready) void'(q.pop_front());
      end
      if (exp_sr && a_s_valid && !a_s_user[ACFG]) begin
        for (int k = 0; k < ANS; k++) begin
          e.d = '0;
          e.k = '0;
          for (int j = 0; j < AM; j++) begin
            if (k * AM + j < AS) begin
              e.d[j*AW +: AW] = a_s_data[(k*AM + j)*AW +: AW];
              e.k[j]          = 1'b1;
            end
          end
          e.l = a_s_last && (k == ANS - 1);
          q.push_back(e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(output logic acc);
    @(negedge clk);
    acc = a_s_valid && a_s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) tick(acc);
  endtask

  task automatic send_a(input logic [AS*AW-1:0] d, input logic [AU-1:0] u, input logic l);
    logic acc;
    int   n;
    a_s_valid = 1'b1;
    a_s_data  = d;
    a_s_user  = u;
    a_s_last  = l;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    chk("s_accept", acc, 1'b1);
    a_s_valid = 1'b0;
  endtask

  function automatic logic [AS*AW-1:0] rand_a();
    return (AS*AW)'({$urandom, $urandom, $urandom});
  endfunction

  logic [AS*AW-1:0] ramp;

  initial begin
    logic        acc;
    int          bi;
    int          oi;
    logic [31:0] ev;

    a_s_valid = 1'b0; a_s_data = '0; a_s_user = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_user = '0; b_s_last = 1'b1; b_m_ready = 1'b1;
    for (int i = 0; i < AS; i++) ramp[i*AW +: AW] = 8'(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Instance B: four back-to-back beats, exact split, expect 8 gapless slices.
    bi = 0;
    oi = 0;
    b_s_valid = 1'b1;
    for (int i = 0; i < BS; i++) b_s_data[i*BW +: BW] = 8'(i);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = b_s_valid && b_s_ready;
      if (c >= 1 && c <= 8) begin
        for (int j = 0; j < BM; j++) ev[j*BW +: BW] = 8'((oi / 2) * 8 + (oi % 2) * 4 + j);
        chk("b_m_valid", b_m_valid, 1'b1);
        chk("b_m_data",  b_m_data,  ev);
        chk("b_m_keep",  b_m_keep,  4'hF);
        chk("b_m_last",  b_m_last,  (oi % 2) == 1);
        oi++;
      end else begin
        chk("b_idle_valid", b_m_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        bi++;
        if (bi < 4) begin
          for (int i = 0; i < BS; i++) b_s_data[i*BW +: BW] = 8'(bi * 8 + i);
        end else begin
          b_s_valid = 1'b0;
        end
      end
    end

    // Instance A: single ramp beat with a short final slice.
    send_a(ramp, '0, 1'b1);
    idle(6);

    // Back-to-back beats at full output rate.
    for (int i = 0; i < 4; i++) send_a(rand_a(), '0, i == 3);
    idle(6);

    // Config beat sandwiched between data beats, then a lone config beat.
    send_a(rand_a(), '0, 1'b0);
    send_a(rand_a(), 4'b0100, 1'b1);
    send_a(rand_a(), '0, 1'b1);
    idle(6);
    send_a(rand_a(), 4'b0100, 1'b1);
    idle(2);

    // Output stall during slice 1.
    send_a(ramp, '0, 1'b1);
    tick(acc);
    a_m_ready = 1'b0;
    idle(2);
    a_m_ready = 1'b1;
    idle(6);

    // Reset while counter is 1, then a fresh beat.
    send_a(rand_a(), '0, 1'b1);
    tick(acc);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    idle(2);
    send_a(ramp, '0, 1'b0);
    idle(6);

    // Randomized traffic with random back-pressure and rare resets.
    a_s_valid = 1'b0;
    acc = 1'b1;
    for (int it = 0; it < 800; it++) begin
      if (acc || !a_s_valid) begin
        a_s_valid = ($urandom % 3) != 0;
        a_s_data  = rand_a();
        a_s_user  = AU'($urandom);
        a_s_user[ACFG] = ($urandom % 5) == 0;
        a_s_last  = $urandom % 2;
      end
      a_m_ready = ($urandom % 4) != 0;
      rst = ($urandom % 150) == 0;
      tick(acc);
      rst = 1'b0;
    end
    a_s_valid = 1'b0;
    a_m_ready = 1'b1;
    idle(8);
    chk("drained_m_valid", a_m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
